// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_if
//  Description : Bundle of the register-file bus between decode/writeback and
//                regfile_mp: read addresses/data/busy, two write ports and the
//                scoreboard-set request.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    rf_raddr  [NUM_RD*ADDR_W]  read addresses, port k at [k*ADDR_W +: ADDR_W]
//    rf_rdata  [NUM_RD*DATA_W]  read data,      port k at [k*DATA_W +: DATA_W]
//    rf_busy   [NUM_RD]         pending-write flag of the addressed register
//    rf_we0/rf_waddr0/rf_wdata0 write port 0 (ALU writeback)
//    rf_we1/rf_waddr1/rf_wdata1 write port 1 (load writeback)
//    sb_set/sb_addr             mark a destination register busy at issue
//  Modports
//    master : pipeline side (drives addresses/writes, receives read data)
//    slave  : register file side
// ============================================================================
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rf_raddr;
    logic [NUM_RD*DATA_W-1:0] rf_rdata;
    logic [NUM_RD-1:0]        rf_busy;
    logic                     rf_we0;
    logic [ADDR_W-1:0]        rf_waddr0;
    logic [DATA_W-1:0]        rf_wdata0;
    logic                     rf_we1;
    logic [ADDR_W-1:0]        rf_waddr1;
    logic [DATA_W-1:0]        rf_wdata1;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;

    modport master (
        output rf_raddr, rf_we0, rf_waddr0, rf_wdata0,
               rf_we1, rf_waddr1, rf_wdata1, sb_set, sb_addr,
        input  rf_rdata, rf_busy
    );

    modport slave (
        input  rf_raddr, rf_we0, rf_waddr0, rf_wdata0,
               rf_we1, rf_waddr1, rf_wdata1, sb_set, sb_addr,
        output rf_rdata, rf_busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port register file with busy scoreboard for the
//                decode/register-read stage. NUM_RD combinational read ports,
//                two write ports (port 1 = load writeback wins collisions),
//                optional hardwired-zero entry 0, per-register busy bits.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    : clock, all state updates on the rising edge
//    reset  : asynchronous active-high, clears array and busy bits at once
//    rf     : regfile_mp_if.slave bus (read ports, write ports, sb_set)
//  Parameters
//    DATA_W   : register width
//    ADDR_W   : address width, depth = 2**ADDR_W
//    NUM_RD   : number of read ports (1..4)
//    ZERO_REG : 1 = entry 0 reads 0, never written, never busy
//  Build option
//    RF_BYPASS_EN : when defined, same-cycle writes are forwarded to the read
//                   ports (data and busy); when undefined, reads see only the
//                   registered array and busy bits.
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  wire          clk,
    input  wire          reset,
    regfile_mp_if.slave  rf
);

    localparam int c_depth = 1 << ADDR_W;

    logic [DATA_W-1:0]  r_mem [c_depth];
    logic [c_depth-1:0] r_busy;

    // Qualified write / scoreboard requests: accesses to entry 0 vanish
    // here when it is hardwired, so neither the array nor the scoreboard
    // ever sees them.
    logic w_wr0;
    logic w_wr1;
    logic w_sb;

    always_comb begin
        w_wr0 = rf.rf_we0;
        w_wr1 = rf.rf_we1;
        w_sb  = rf.sb_set;
        if (ZERO_REG != 0) begin
            if (rf.rf_waddr0 == '0) w_wr0 = 1'b0;
            if (rf.rf_waddr1 == '0) w_wr1 = 1'b0;
            if (rf.sb_addr   == '0) w_sb  = 1'b0;
        end
    end

    // Register array. Port 1 is assigned last so that, on an address
    // collision, the load writeback value is the one committed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr0) r_mem[rf.rf_waddr0] <= rf.rf_wdata0;
            if (w_wr1) r_mem[rf.rf_waddr1] <= rf.rf_wdata1;
        end
    end

    // Busy scoreboard. The set is applied after both clears: a same-edge
    // issue to a register being written back belongs to a newer producer,
    // so the register must stay busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (w_wr0) r_busy[rf.rf_waddr0] <= 1'b0;
            if (w_wr1) r_busy[rf.rf_waddr1] <= 1'b0;
            if (w_sb)  r_busy[rf.sb_addr]   <= 1'b1;
        end
    end

    // Read ports: zero-latency lookup with optional write-through forwarding.
    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_raddr;
            logic [DATA_W-1:0] w_data;
            logic              w_busy;
`ifdef RF_BYPASS_EN
            logic              w_hit0;
            logic              w_hit1;
            logic              w_sb_hit;
`endif

            assign w_raddr = rf.rf_raddr[k*ADDR_W +: ADDR_W];

            always_comb begin
                w_data = r_mem[w_raddr];
                w_busy = r_busy[w_raddr];
`ifdef RF_BYPASS_EN
                // Forwarding is gated by reset so that everything reads 0
                // while the file is held in reset.
                w_hit0   = w_wr0 && (rf.rf_waddr0 == w_raddr) && !reset;
                w_hit1   = w_wr1 && (rf.rf_waddr1 == w_raddr) && !reset;
                w_sb_hit = w_sb  && (rf.sb_addr   == w_raddr);
                if (w_hit1) begin
                    w_data = rf.rf_wdata1;
                end else if (w_hit0) begin
                    w_data = rf.rf_wdata0;
                end
                // A retiring write releases the operand this cycle unless a
                // newer producer is issuing to the same register.
                if ((w_hit0 || w_hit1) && !w_sb_hit) begin
                    w_busy = 1'b0;
                end
`endif
                if ((ZERO_REG != 0) && (w_raddr == '0)) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end
            end

            assign rf.rf_rdata[k*DATA_W +: DATA_W] = w_data;
            assign rf.rf_busy[k]                   = w_busy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write, two-read register file. Sits in the decode/register-read stage of the pipelined core.
- Provides NUM_RD combinational read ports and two write ports (ALU writeback and load writeback).
- Architectural register 0 can optionally be hardwired to zero.
- A per-register busy scoreboard lets decode stall on operands that have in-flight writes pending.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0, and writes to entry 0 are discarded and never set busy

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
rf_raddr  in  NUM_RD*ADDR_W  read addresses; port k uses slice [k*ADDR_W +: ADDR_W]
rf_rdata  out  NUM_RD*DATA_W  read data; port k uses slice [k*DATA_W +: DATA_W]
rf_busy  out  NUM_RD  1 = register addressed by read port k has a pending write
rf_we0  in  1  write enable, port 0 (ALU writeback)
rf_waddr0  in  ADDR_W  write address, port 0
rf_wdata0  in  DATA_W  write data, port 0
rf_we1  in  1  write enable, port 1 (load writeback)
rf_waddr1  in  ADDR_W  write address, port 1
rf_wdata1  in  DATA_W  write data, port 1
sb_set  in  1  issue of an instruction with a destination register: mark it busy
sb_addr  in  ADDR_W  destination register to mark busy

Behaviour:
- Storage: 2**ADDR_W x DATA_W register array, plus 2**ADDR_W busy bits.
- Reset (asynchronous): while reset=1, every entry=0 and every busy bit=0. rf_rdata=0 and rf_busy=0 on all ports. Writes and sb_set are ignored. On reset deassertion, normal operation starts at the next rising edge.
- Write, each port with weN=1: entry[waddrN] <= wdataN at the rising edge.
- Write collision: both ports enabled to the same address → port 1 (load) wins.
- Different addresses on the two ports: both writes are committed in the same cycle.
- ZERO_REG=1: writes to address 0 are dropped, sb_set to address 0 is dropped, and read port data for address 0 is forced to 0 with busy=0.
- Read: combinational, zero latency. rf_rdata[k] = entry[raddr k], with bypass per Optional Feature.
- Scoreboard clear: a write on either port clears busy[waddr] at the edge.
- Scoreboard set: sb_set=1 sets busy[sb_addr] at the edge.
- Same-edge set and clear of the same address: set wins, because a newer writer has issued.
- Clears to a register that is not busy: harmless, busy stays 0.
- rf_busy[k] = busy[raddr k], with bypass per Optional Feature.
- No internal FSM beyond the array and scoreboard; all outputs are combinational functions of state and inputs.

Optional Feature:
Macro: RF_BYPASS_EN
- Defined (write-through):
  - A read whose address matches an enabled write port in the same cycle returns that write's data; on a double match, the port 1 data is returned.
  - rf_busy[k] reads 0 when a same-cycle write targets raddr k and there is no same-cycle sb_set to that address.
  - Both forwarding paths are suppressed while reset=1.
- Undefined:
  - Reads return the pre-edge array contents; written data becomes visible in the cycle after the edge.
  - rf_busy reflects only the registered busy bits.

Test Plan:
1. Reset then read: assert reset mid-run after writing 0xDEADBEEF to r5 → r5 reads 0 and rf_busy=0 immediately, without waiting for a clock edge.
2. Basic write/read: we0=1, waddr0=3, wdata0=0x12345678; next cycle raddr port0=3, port1=0 → rdata0=0x12345678, rdata1=0. With ZERO_REG=1, a write of 0xFFFFFFFF to r0 still reads 0.
3. Collision: in one cycle, we0 writes 0xAAAA0000 to r7 and we1 writes 0x0000BBBB to r7 → r7 reads 0x0000BBBB afterwards.
4. Bypass: same-cycle write of 0xCAFEF00D to r9 with raddr=9 → rdata=0xCAFEF00D with RF_BYPASS_EN defined; rdata equals the old value with it undefined, and 0xCAFEF00D one cycle later.
5. Scoreboard:
   - sb_set r4 → rf_busy=1 on a port reading r4.
   - Then write r4 → busy=0 after the edge (same cycle with RF_BYPASS_EN defined).
   - Same-edge sb_set r4 plus we1 to r4 → busy stays 1.
6. Dual write: port0 writes 0x11 to r1 and port1 writes 0x22 to r2 in the same cycle with NUM_RD=4 → all four ports read correctly (r1=0x11, r2=0x22, r0=0, r31=prior value).
